sorted_node_reader: RTL

//  Reader side of the sorted even/odd RAM pair filled by the heap sorter.

---
 rtl/sorted_node_reader.sv | 102 ++++++++++
 1 files changed

// File: rtl/sorted_node_reader.sv
// sorted_node_reader: streams the ascending even/odd sorted RAM pair as 36-bit frames.
// Optional SKIP_ZERO_FREQ_EN drops zero-frequency entries without presenting them.
module sorted_node_reader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 36,
   parameter int FREQ_W = 27
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              read_start,
   output logic              read_done,
   output logic              sorted_even_wea,
   output logic [ADDR_W-1:0] sorted_even_addra,
   output logic [DATA_W-1:0] sorted_even_dina,
   input  logic [DATA_W-1:0] sorted_even_douta,
   output logic              sorted_odd_wea,
   output logic [ADDR_W-1:0] sorted_odd_addra,
   output logic [DATA_W-1:0] sorted_odd_dina,
   input  logic [DATA_W-1:0] sorted_odd_douta,
   output logic              node_valid,
   input  logic              node_ready,
   output logic [DATA_W-1:0] node_data,
   output logic              node_last,
   output logic [8:0]        leaf_cnt,
   output logic              order_err
);
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, EMIT_E, EMIT_O, DONE} state_t;
   state_t state, state_nxt;
   logic read_start_d1, start_acc, emit, skip, accept, adv, last_pair, first;
   logic [ADDR_W-1:0] pair_addr;
   logic [DATA_W-1:0] pair_e, pair_o, cur;
   logic [FREQ_W-1:0] cur_freq, last_freq;
   assign start_acc = (state == IDLE || state == DONE) && read_start && !read_start_d1;
   assign emit = state == EMIT_E || state == EMIT_O;
   assign cur = state == EMIT_O ? pair_o : pair_e;
   assign cur_freq = cur[FREQ_W-1:0];
`ifdef SKIP_ZERO_FREQ_EN
   assign skip = emit && cur_freq == '0;
`else
   assign skip = 1'b0;
`endif
   assign node_valid = emit && !skip;
   assign node_data = emit ? cur : '0;
   assign accept = node_valid && node_ready;
   assign adv = accept || skip;
   assign last_pair = pair_addr == '1;
   assign node_last = node_valid && state == EMIT_O && last_pair;
   assign read_done = state == DONE;
   assign sorted_even_wea = 1'b0;
   assign sorted_odd_wea = 1'b0;
   assign sorted_even_dina = '0;
   assign sorted_odd_dina = '0;
   assign sorted_even_addra = pair_addr;
   assign sorted_odd_addra = pair_addr;
   always_ff @(posedge clk or negedge rstN)
      if (!rstN) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start_acc ? FETCH : IDLE;
         FETCH:   state_nxt = LATCH;
         LATCH:   state_nxt = EMIT_E;
         EMIT_E:  state_nxt = adv ? EMIT_O : EMIT_E;
         EMIT_O:  state_nxt = adv ? (last_pair ? DONE : FETCH) : EMIT_O;
         DONE:    state_nxt = start_acc ? FETCH : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         read_start_d1 <= 1'b0;
         pair_addr <= '0;
         pair_e <= '0;
         pair_o <= '0;
         last_freq <= '0;
         first <= 1'b0;
         leaf_cnt <= '0;
         order_err <= 1'b0;
      end else begin
         read_start_d1 <= read_start;
         if (start_acc) begin
            pair_addr <= '0;
            leaf_cnt <= '0;
            order_err <= 1'b0;
            first <= 1'b1;
         end
         if (state == LATCH) begin
            pair_e <= sorted_even_douta;
            pair_o <= sorted_odd_douta;
         end
         if (state == EMIT_O && adv && !last_pair) pair_addr <= pair_addr + 1'b1;
         // first entry of a pass has no predecessor to compare against
         if (accept) begin
            leaf_cnt <= leaf_cnt == 9'd256 ? leaf_cnt : leaf_cnt + 9'd1;
            first <= 1'b0;
            last_freq <= cur_freq;
            if (!first && cur_freq < last_freq) order_err <= 1'b1;
         end
      end
   end
endmodule
